// File: rtl/riscv_defs.sv
// rtl/riscv_defs.sv - shared opcodes, enums and immediate builder for cpu_multicycle
// Contents: RV32I opcode constants, immediate/ALU/state enums, imm_gen().
package riscv_defs;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B} t_imm;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_PASS} t_alu_op;
  typedef enum logic [2:0] {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT} t_mc_state;

  // Sign-extended immediate for the given instruction format.
  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input t_imm sel);
    case (sel)
      IMM_S:   imm_gen = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_gen = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm_gen = {{20{instr[31]}}, instr[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - state register, next-state and control decode for cpu_multicycle
// Ports: clk_i/rst_i (sync active-high), instruction fields in, memory readies in,
//        a_eq_b_i branch compare in; state, write enables, memory strobes, ALU op,
//        operand/immediate selects, pc load controls and retire strobe out.
// Option: CPU_MC_ILLEGAL_TRAP_EN halts on unsupported instructions and adds illegal_o.
module mc_controller
  import riscv_defs::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       im_ready_i,
  input  logic       dm_ready_i,
  input  logic       a_eq_b_i,
  output logic [2:0] state_o,
  output logic       ir_we_o,
  output logic       rf_we_o,
  output logic       rf_sel_mdr_o,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic [2:0] alu_op_o,
  output logic       alu_b_imm_o,
  output logic [1:0] imm_sel_o,
  output logic       pc_we_o,
  output logic       pc_sel_branch_o,
  output logic       retire_o
`ifdef CPU_MC_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_o
`endif
);

  t_mc_state state_q, state_d;
  t_alu_op   rtype_op, alu_op;
  t_imm      imm_sel;
  logic      is_rtype, is_addi, is_lw, is_sw, is_beq;

  always_comb begin
    is_rtype = 1'b0;
    rtype_op = ALU_PASS;
    if (opcode_i == OP) begin
      case ({funct7_i, funct3_i})
        {7'b0000000, 3'b000}: begin is_rtype = 1'b1; rtype_op = ALU_ADD; end
        {7'b0100000, 3'b000}: begin is_rtype = 1'b1; rtype_op = ALU_SUB; end
        {7'b0000000, 3'b111}: begin is_rtype = 1'b1; rtype_op = ALU_AND; end
        {7'b0000000, 3'b110}: begin is_rtype = 1'b1; rtype_op = ALU_OR;  end
        default: ;
      endcase
    end
  end

  assign is_addi = (opcode_i == OP_IMM) && (funct3_i == 3'b000);
  assign is_lw   = (opcode_i == LOAD)   && (funct3_i == 3'b010);
  assign is_sw   = (opcode_i == STORE)  && (funct3_i == 3'b010);
  assign is_beq  = (opcode_i == BRANCH) && (funct3_i == 3'b000);

  always_comb begin
    alu_op  = is_rtype ? rtype_op : ((is_addi || is_lw || is_sw) ? ALU_ADD : ALU_PASS);
    imm_sel = is_sw ? IMM_S : (is_beq ? IMM_B : IMM_I);
  end

  always_comb begin
    state_d         = state_q;
    ir_we_o         = 1'b0;
    rf_we_o         = 1'b0;
    pc_we_o         = 1'b0;
    pc_sel_branch_o = 1'b0;
    retire_o        = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (im_ready_i) begin
          ir_we_o = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (is_beq) begin
          pc_we_o         = 1'b1;
          pc_sel_branch_o = a_eq_b_i;
          retire_o        = 1'b1;
          state_d         = ST_FETCH;
        end else if (is_rtype || is_addi) begin
          state_d = ST_WB;
        end else if (is_lw || is_sw) begin
          state_d = ST_MEM;
        end else begin
`ifdef CPU_MC_ILLEGAL_TRAP_EN
          state_d = ST_HALT;
`else
          // Unsupported encodings retire as a NOP.
          pc_we_o  = 1'b1;
          retire_o = 1'b1;
          state_d  = ST_FETCH;
`endif
        end
      end
      ST_MEM: begin
        if (dm_ready_i) begin
          if (is_lw) begin
            state_d = ST_WB;
          end else begin
            pc_we_o  = 1'b1;
            retire_o = 1'b1;
            state_d  = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        rf_we_o  = 1'b1;
        pc_we_o  = 1'b1;
        retire_o = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  assign state_o      = state_q;
  assign mem_rd_o     = (state_q == ST_MEM) && is_lw;
  assign mem_wr_o     = (state_q == ST_MEM) && is_sw;
  assign rf_sel_mdr_o = is_lw;
  assign alu_b_imm_o  = !is_rtype;
  assign alu_op_o     = alu_op;
  assign imm_sel_o    = imm_sel;
`ifdef CPU_MC_ILLEGAL_TRAP_EN
  assign illegal_o    = (state_q == ST_HALT);
`endif

endmodule

// File: rtl/cpu_multicycle.sv
// rtl/cpu_multicycle.sv - multi-cycle RV32I-subset CPU (ADDI/ADD/SUB/AND/OR/LW/SW/BEQ)
// Ports: iCPU_Clk, iCPU_Reset (sync active-high); instruction fetch oIM_Addr/oIM_Req/
//        iIM_Ready/iIM_Data; data access oAB/oWriteData/oRD/oWR/iDM_Ready/iReadData;
//        debug oCurrent_PC/oFetch/oRetire.
// Option: CPU_MC_ILLEGAL_TRAP_EN adds oIllegal and halts on unsupported instructions.
module cpu_multicycle
  import riscv_defs::*;
#(
  parameter int                   DATAWIDTH = 32,
  parameter int                   ADDRWIDTH = 32,
  parameter logic [ADDRWIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 iCPU_Clk,
  input  logic                 iCPU_Reset,
  output logic [ADDRWIDTH-1:0] oIM_Addr,
  output logic                 oIM_Req,
  input  logic                 iIM_Ready,
  input  logic [DATAWIDTH-1:0] iIM_Data,
  output logic [ADDRWIDTH-1:0] oAB,
  output logic [DATAWIDTH-1:0] oWriteData,
  output logic                 oRD,
  output logic                 oWR,
  input  logic                 iDM_Ready,
  input  logic [DATAWIDTH-1:0] iReadData,
  output logic [ADDRWIDTH-1:0] oCurrent_PC,
  output logic                 oFetch,
  output logic                 oRetire
`ifdef CPU_MC_ILLEGAL_TRAP_EN
  ,
  output logic                 oIllegal
`endif
);

  if (DATAWIDTH != 32) begin : g_width_check
    $error("cpu_multicycle supports DATAWIDTH=32 only");
  end

  logic [ADDRWIDTH-1:0] pc_q;
  logic [31:0]          ir_q, a_q, b_q, y_q, mdr_q, imm_q;
  logic [31:0]          rf_q [32];
  logic                 retire_q;

  logic [2:0]  state, alu_op;
  logic [1:0]  imm_sel;
  logic        ir_we, rf_we, rf_sel_mdr, mem_rd, mem_wr, alu_b_imm;
  logic        pc_we, pc_sel_branch, retire;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_y;

  assign rd  = ir_q[11:7];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];

  mc_controller u_ctrl (
    .clk_i           (iCPU_Clk),
    .rst_i           (iCPU_Reset),
    .opcode_i        (ir_q[6:0]),
    .funct3_i        (ir_q[14:12]),
    .funct7_i        (ir_q[31:25]),
    .im_ready_i      (iIM_Ready),
    .dm_ready_i      (iDM_Ready),
    .a_eq_b_i        (a_q == b_q),
    .state_o         (state),
    .ir_we_o         (ir_we),
    .rf_we_o         (rf_we),
    .rf_sel_mdr_o    (rf_sel_mdr),
    .mem_rd_o        (mem_rd),
    .mem_wr_o        (mem_wr),
    .alu_op_o        (alu_op),
    .alu_b_imm_o     (alu_b_imm),
    .imm_sel_o       (imm_sel),
    .pc_we_o         (pc_we),
    .pc_sel_branch_o (pc_sel_branch),
    .retire_o        (retire)
`ifdef CPU_MC_ILLEGAL_TRAP_EN
    ,
    .illegal_o       (oIllegal)
`endif
  );

  // x0 is hardwired to zero on the read side; entry 0 is never written.
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

  always_comb begin
    alu_b = alu_b_imm ? imm_q : b_q;
    alu_y = alu_b;
    case (alu_op)
      ALU_ADD: alu_y = a_q + alu_b;
      ALU_SUB: alu_y = a_q - alu_b;
      ALU_AND: alu_y = a_q & alu_b;
      ALU_OR:  alu_y = a_q | alu_b;
      default: alu_y = alu_b;
    endcase
  end

  always_ff @(posedge iCPU_Clk) begin
    if (iCPU_Reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      retire_q <= 1'b0;
    end else begin
      retire_q <= retire;
      if (ir_we) ir_q <= iIM_Data;
      if (pc_we) pc_q <= pc_sel_branch ? pc_q + ADDRWIDTH'(imm_q) : pc_q + ADDRWIDTH'(4);
    end
  end

  // Operand, result and register-file state needs no reset: every value is
  // written by the FSM before it can be observed.
  always_ff @(posedge iCPU_Clk) begin
    if (state == ST_DECODE) begin
      a_q   <= rs1_val;
      b_q   <= rs2_val;
      imm_q <= imm_gen(ir_q, t_imm'(imm_sel));
    end
    if (state == ST_EXEC) y_q <= alu_y;
    if (mem_rd && iDM_Ready) mdr_q <= iReadData;
    if (rf_we && !iCPU_Reset && rd != 5'd0) rf_q[rd] <= rf_sel_mdr ? mdr_q : y_q;
  end

  assign oIM_Addr    = pc_q;
  assign oIM_Req     = (state == ST_FETCH);
  assign oFetch      = (state == ST_FETCH);
  assign oCurrent_PC = pc_q;
  assign oRetire     = retire_q;
  assign oRD         = mem_rd;
  assign oWR         = mem_wr;
  assign oAB         = (mem_rd || mem_wr) ? ADDRWIDTH'(y_q) : '0;
  assign oWriteData  = mem_wr ? b_q : '0;

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb/tb_cpu_multicycle.sv - self-checking bench for cpu_multicycle against an ISA-level model
module tb_cpu_multicycle;

  localparam logic [6:0] T_OP_IMM = 7'b0010011;
  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;

  logic        clk = 1'b0;
  logic        iCPU_Reset, iIM_Ready, iDM_Ready;
  logic [31:0] iIM_Data, iReadData;
  logic [31:0] oIM_Addr, oAB, oWriteData, oCurrent_PC;
  logic        oIM_Req, oRD, oWR, oFetch, oRetire;
`ifdef CPU_MC_ILLEGAL_TRAP_EN
  logic        oIllegal;
`endif

  always #5 clk = ~clk;

  cpu_multicycle dut (
    .iCPU_Clk    (clk),
    .iCPU_Reset  (iCPU_Reset),
    .oIM_Addr    (oIM_Addr),
    .oIM_Req     (oIM_Req),
    .iIM_Ready   (iIM_Ready),
    .iIM_Data    (iIM_Data),
    .oAB         (oAB),
    .oWriteData  (oWriteData),
    .oRD         (oRD),
    .oWR         (oWR),
    .iDM_Ready   (iDM_Ready),
    .iReadData   (iReadData),
    .oCurrent_PC (oCurrent_PC),
    .oFetch      (oFetch),
    .oRetire     (oRetire)
`ifdef CPU_MC_ILLEGAL_TRAP_EN
    ,
    .oIllegal    (oIllegal)
`endif
  );

  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [64];
  logic [31:0] m_pc;
  logic [31:0] last_ir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3,
                                        input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], T_OP};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], T_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], T_BRANCH};
  endfunction

  task automatic do_reset();
    iCPU_Reset = 1'b1;
    step();
    step();
    iCPU_Reset = 1'b0;
    m_pc    = 32'd0;
    last_ir = 32'd0;
  endtask

  // Fetch and execute one instruction with imw fetch-wait and dmw data-wait cycles,
  // predicting its effect from the ISA rules and checking the DUT's ports.
  task automatic run_instr(input logic [31:0] instr, input int imw, input int dmw);
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    int          rd, rs1, rs2, lat, kind, cycles, mw, strobes;
    logic [31:0] a, b, imm_i, imm_s, imm_b, wval, maddr, mdata, exp_pc, first_ab, first_wd;
    bit          wr, stable;
    op  = instr[6:0];
    f3  = instr[14:12];
    f7  = instr[31:25];
    rd  = int'(instr[11:7]);
    rs1 = int'(instr[19:15]);
    rs2 = int'(instr[24:20]);
    a   = m_reg[rs1];
    b   = m_reg[rs2];
    imm_i = 32'($signed(instr) >>> 20);
    imm_s = {imm_i[31:5], instr[11:7]};
    imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    exp_pc = m_pc + 32'd4;
    wr = 0; wval = 0; kind = 0; maddr = 0; mdata = 0; lat = 3;
    if (op == T_OP_IMM && f3 == 3'd0) begin wr = 1; wval = a + imm_i; lat = 4; end
    else if (op == T_OP && f3 == 3'd0 && f7 == 7'h00) begin wr = 1; wval = a + b; lat = 4; end
    else if (op == T_OP && f3 == 3'd0 && f7 == 7'h20) begin wr = 1; wval = a - b; lat = 4; end
    else if (op == T_OP && f3 == 3'd7 && f7 == 7'h00) begin wr = 1; wval = a & b; lat = 4; end
    else if (op == T_OP && f3 == 3'd6 && f7 == 7'h00) begin wr = 1; wval = a | b; lat = 4; end
    else if (op == T_LOAD && f3 == 3'd2) begin
      kind = 1; maddr = a + imm_i; wr = 1; wval = m_mem[maddr[7:2]]; lat = 5 + dmw;
    end else if (op == T_STORE && f3 == 3'd2) begin
      kind = 2; maddr = a + imm_s; mdata = b; lat = 4 + dmw;
    end else if (op == T_BRANCH && f3 == 3'd0) begin
      if (a == b) exp_pc = m_pc + imm_b;
    end
    lat += imw;

    cycles = 0; mw = 0; strobes = 0; stable = 1; first_ab = 0; first_wd = 0;
    check("fetch_addr", oIM_Addr, m_pc);
    iIM_Data  = instr;
    iIM_Ready = 1'b0;
    for (int i = 0; i < imw; i++) begin
      step();
      cycles++;
    end
    if (imw > 0) begin
      check("fetch_wait_req", oIM_Req, 1);
      check("fetch_wait_fetch", oFetch, 1);
      check("fetch_wait_pc", oCurrent_PC, m_pc);
      check("fetch_wait_ir", dut.ir_q, last_ir);
      check("retire_one_cycle", oRetire, 0);
    end
    iIM_Ready = 1'b1;
    step();
    cycles++;
    iIM_Ready = 1'b0;
    iIM_Data  = $urandom();
    while (oFetch !== 1'b1 && cycles < 64) begin
      iDM_Ready = 1'b0;
      if (oRD === 1'b1 || oWR === 1'b1) begin
        if (strobes == 0) begin
          first_ab = oAB;
          first_wd = oWriteData;
          check("mem_addr", oAB, maddr);
          check("mem_rd", oRD, kind == 1);
          check("mem_wr", oWR, kind == 2);
          if (kind == 2) check("mem_wdata", oWriteData, mdata);
        end else if (oAB !== first_ab || oWriteData !== first_wd) begin
          stable = 0;
        end
        if (oRD === 1'b1 && oWR === 1'b1) stable = 0;
        strobes++;
        if (mw < dmw) mw++;
        else begin
          iDM_Ready = 1'b1;
          iReadData = (kind == 1) ? m_mem[maddr[7:2]] : $urandom();
        end
      end
      step();
      cycles++;
    end
    iDM_Ready = 1'b0;
    check("latency", cycles, lat);
    check("retire", oRetire, 1);
    check("pc", oCurrent_PC, exp_pc);
    check("mem_strobe_cycles", strobes, (kind == 0) ? 0 : dmw + 1);
    if (kind != 0) check("mem_stable", stable, 1);
    if (wr && rd != 0) check("rd_value", dut.rf_q[rd], wval);
    m_pc    = exp_pc;
    last_ir = instr;
    if (wr && rd != 0) m_reg[rd] = wval;
    if (kind == 2) m_mem[maddr[7:2]] = mdata;
  endtask

  initial begin
    int          sel, rd, rs1, rs2, imm, imw, dmw;
    logic [31:0] instr;
    iCPU_Reset = 1'b1;
    iIM_Ready  = 1'b0;
    iIM_Data   = 32'd0;
    iDM_Ready  = 1'b0;
    iReadData  = 32'd0;
    foreach (m_reg[i]) m_reg[i] = 32'd0;
    foreach (m_mem[i]) m_mem[i] = 32'd0;

    do_reset();
    check("reset_fetch", oFetch, 1);
    check("reset_im_req", oIM_Req, 1);
    check("reset_rd", oRD, 0);
    check("reset_wr", oWR, 0);
    check("reset_ab", oAB, 0);
    check("reset_wdata", oWriteData, 0);
    check("reset_retire", oRetire, 0);
    check("reset_pc", oCurrent_PC, 0);

    run_instr(enc_i(5, 0, 0, 1, T_OP_IMM), 0, 0);
    run_instr(enc_i(-1, 0, 0, 1, T_OP_IMM), 0, 0);
    run_instr(enc_r(0, 1, 1, 0, 2), 0, 0);
    run_instr(enc_r(32, 1, 0, 0, 3), 0, 0);
    run_instr(enc_i(7, 0, 0, 0, T_OP_IMM), 0, 0);
    run_instr(enc_s(0, 0, 0), 0, 0);
    run_instr(enc_s(8, 2, 0), 0, 3);
    run_instr(enc_i(8, 0, 2, 4, T_LOAD), 0, 3);

    do_reset();
    for (int i = 0; i < 4; i++) run_instr(enc_i(i, 0, 0, 5, T_OP_IMM), 0, 0);
    run_instr(enc_b(-8, 1, 1), 0, 0);
    run_instr(enc_i(12'h123, 0, 0, 6, T_OP_IMM), 0, 0);
    run_instr(enc_i(-5, 0, 0, 7, T_OP_IMM), 0, 0);
    run_instr(enc_b(12, 2, 1), 0, 0);
    run_instr(enc_i(1, 5, 0, 5, T_OP_IMM), 5, 0);

    // Reset while an LW is waiting in MEM: the load must be abandoned.
    iIM_Data  = enc_i(12, 0, 2, 6, T_LOAD);
    iIM_Ready = 1'b1;
    step();
    iIM_Ready = 1'b0;
    step();
    step();
    check("lw_req_before_reset", oRD, 1);
    iReadData  = 32'hDEAD_BEEF;
    iCPU_Reset = 1'b1;
    step();
    iCPU_Reset = 1'b0;
    check("reset_mid_mem_rd", oRD, 0);
    check("reset_mid_mem_pc", oCurrent_PC, 0);
    check("reset_mid_mem_fetch", oFetch, 1);
    check("reset_mid_mem_rd_kept", dut.rf_q[6], m_reg[6]);
    m_pc    = 32'd0;
    last_ir = 32'd0;

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 8);
      rd  = $urandom_range(0, 7);
      rs1 = $urandom_range(0, 7);
      rs2 = ($urandom_range(0, 1) == 0) ? rs1 : $urandom_range(0, 7);
      imm = $urandom_range(0, 4095) - 2048;
      imw = $urandom_range(0, 2);
      dmw = $urandom_range(0, 3);
      case (sel)
        0: instr = enc_i(imm, rs1, 0, rd, T_OP_IMM);
        1: instr = enc_r(0, rs2, rs1, 0, rd);
        2: instr = enc_r(32, rs2, rs1, 0, rd);
        3: instr = enc_r(0, rs2, rs1, 7, rd);
        4: instr = enc_r(0, rs2, rs1, 6, rd);
        5: instr = enc_i(4 * $urandom_range(0, 63), 0, 2, rd, T_LOAD);
        6: instr = enc_s(4 * $urandom_range(0, 63), rs2, 0);
        7: instr = enc_b(4 * ($urandom_range(0, 8) - 4), rs2, rs1);
        default: begin
`ifdef CPU_MC_ILLEGAL_TRAP_EN
          instr = enc_i(imm, rs1, 0, rd, T_OP_IMM);
`else
          instr = (n % 2 == 0) ? enc_r(0, rs2, rs1, 4, rd) : 32'h0000_007F;
`endif
        end
      endcase
      run_instr(instr, imw, dmw);
    end

`ifdef CPU_MC_ILLEGAL_TRAP_EN
    iIM_Data  = 32'h0000_007F;
    iIM_Ready = 1'b1;
    step();
    iIM_Ready = 1'b0;
    step();
    step();
    check("halt_illegal", oIllegal, 1);
    check("halt_fetch", oFetch, 0);
    check("halt_im_req", oIM_Req, 0);
    repeat (5) step();
    check("halt_stays", oIllegal, 1);
    check("halt_pc_frozen", oCurrent_PC, m_pc);
    check("halt_retire", oRetire, 0);
    check("halt_no_mem", {oRD, oWR}, 0);
    do_reset();
    check("halt_cleared", oIllegal, 0);
    check("halt_reset_fetch", oFetch, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
